// File: rtl/l1_snoop_responder_if.sv
// Snoop, data-array and CPU state-port bundle of the L1 snoop responder.
// master = coherency unit / L1 environment side, slave = responder.
interface l1_snoop_responder_if #(
    parameter int unsigned SET_W  = 4,
    parameter int unsigned WORD_W = 1
);
    logic              snoop_req;
    logic [SET_W-1:0]  set_sel;
    logic [1:0]        state_transfer;
    logic              snoop_ack;
    logic              valid;
    logic              exclusive;
    logic              dirty;
    logic [31:0]       requested_data;
    logic              data_valid;
    logic [WORD_W-1:0] word_idx;
    logic              snoop_done;
    logic              busy;
    logic              data_ren;
    logic [SET_W-1:0]  data_set;
    logic [WORD_W-1:0] data_word;
    logic [31:0]       data_rdata;
    logic [SET_W-1:0]  cpu_set;
    logic              cpu_state_wen;
    logic [1:0]        cpu_state_in;
    logic [1:0]        cpu_state_out;

    modport master (
        output snoop_req, set_sel, state_transfer, data_rdata,
               cpu_set, cpu_state_wen, cpu_state_in,
        input  snoop_ack, valid, exclusive, dirty, requested_data, data_valid,
               word_idx, snoop_done, busy, data_ren, data_set, data_word, cpu_state_out
    );

    modport slave (
        input  snoop_req, set_sel, state_transfer, data_rdata,
               cpu_set, cpu_state_wen, cpu_state_in,
        output snoop_ack, valid, exclusive, dirty, requested_data, data_valid,
               word_idx, snoop_done, busy, data_ren, data_set, data_word, cpu_state_out
    );
endinterface

// File: rtl/l1_snoop_responder.sv
// Cache-side snoop responder: owns the per-set MESI array of one L1, answers snoops,
// flushes dirty blocks from the data array and commits the coherency unit's end state.
module l1_snoop_responder #(
    parameter int unsigned CACHE_SIZE = 1024,
    parameter int unsigned BLOCK_SIZE = 2,
    parameter int unsigned ASSOC      = 1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    l1_snoop_responder_if.slave   bus
);
    localparam int unsigned N_SETS = CACHE_SIZE / 8 / 4 / BLOCK_SIZE / ASSOC;
    localparam int unsigned SET_W  = (N_SETS > 1) ? $clog2(N_SETS) : 1;
    localparam int unsigned WORD_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam int unsigned CNT_W  = $clog2(BLOCK_SIZE + 1);

    localparam logic [1:0] MESI_M = 2'd0;
    localparam logic [1:0] MESI_E = 2'd1;
    localparam logic [1:0] MESI_I = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOOKUP, ST_RESP, ST_FLUSH, ST_UPDATE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [SET_W-1:0]  r_set;
    logic [1:0]        r_xfer;
    logic [1:0]        r_mesi [N_SETS];
    logic [1:0]        w_lookup;

    logic              r_ack, r_valid, r_excl, r_dirty, r_dvalid, r_done, r_busy, r_ren;
    logic [WORD_W-1:0] r_widx, r_dword;
    logic [SET_W-1:0]  r_dset;
    logic              w_ack_nxt, w_valid_nxt, w_excl_nxt, w_dirty_nxt;
    logic              w_dvalid_nxt, w_done_nxt, w_busy_nxt, w_ren_nxt;
    logic [WORD_W-1:0] w_widx_nxt, w_dword_nxt;
    logic [SET_W-1:0]  w_dset_nxt;

    assign w_lookup = r_mesi[r_set];

    // Next state plus next-cycle outputs, decoded from the state being entered.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ack_nxt    = 1'b0;
        w_valid_nxt  = 1'b0;
        w_excl_nxt   = 1'b0;
        w_dirty_nxt  = 1'b0;
        w_dvalid_nxt = 1'b0;
        w_widx_nxt   = '0;
        w_done_nxt   = 1'b0;
        w_ren_nxt    = 1'b0;
        w_dset_nxt   = '0;
        w_dword_nxt  = '0;

        case (r_state)
            ST_IDLE:   if (bus.snoop_req) w_state_nxt = ST_LOOKUP;
            ST_LOOKUP: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = r_dirty ? ST_FLUSH : ST_UPDATE;
            ST_FLUSH: begin
                if (r_cnt == CNT_W'(BLOCK_SIZE)) begin
                    w_state_nxt = ST_UPDATE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            ST_UPDATE: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = (w_state_nxt == ST_UPDATE);

        if (w_state_nxt == ST_RESP) begin
            w_ack_nxt   = 1'b1;
            w_valid_nxt = (w_lookup != MESI_I);
            w_excl_nxt  = (w_lookup == MESI_M) || (w_lookup == MESI_E);
            w_dirty_nxt = (w_lookup == MESI_M);
        end

        // Read word c is issued in flush cycle c; its data returns in cycle c+1.
        if (w_state_nxt == ST_FLUSH) begin
            if (w_cnt_nxt < CNT_W'(BLOCK_SIZE)) begin
                w_ren_nxt   = 1'b1;
                w_dset_nxt  = r_set;
                w_dword_nxt = WORD_W'(w_cnt_nxt);
            end
            if (w_cnt_nxt != '0) begin
                w_dvalid_nxt = 1'b1;
                w_widx_nxt   = WORD_W'(w_cnt_nxt - CNT_W'(1));
            end
        end
    end

    // State, snoop latch, MESI array and registered outputs.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_set    <= '0;
            r_xfer   <= '0;
            r_ack    <= 1'b0;
            r_valid  <= 1'b0;
            r_excl   <= 1'b0;
            r_dirty  <= 1'b0;
            r_dvalid <= 1'b0;
            r_widx   <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_ren    <= 1'b0;
            r_dset   <= '0;
            r_dword  <= '0;
            for (int i = 0; i < int'(N_SETS); i++) begin
                r_mesi[i] <= MESI_I;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ack    <= w_ack_nxt;
            r_valid  <= w_valid_nxt;
            r_excl   <= w_excl_nxt;
            r_dirty  <= w_dirty_nxt;
            r_dvalid <= w_dvalid_nxt;
            r_widx   <= w_widx_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
            r_ren    <= w_ren_nxt;
            r_dset   <= w_dset_nxt;
            r_dword  <= w_dword_nxt;
            if ((r_state == ST_IDLE) && bus.snoop_req) begin
                r_set  <= bus.set_sel;
                r_xfer <= bus.state_transfer;
            end
            // CPU writes land only while idle, so the snoop owns the array once started.
            if (r_state == ST_UPDATE) begin
                r_mesi[r_set] <= r_xfer;
            end else if ((r_state == ST_IDLE) && bus.cpu_state_wen) begin
                r_mesi[bus.cpu_set] <= bus.cpu_state_in;
            end
        end
    end

    assign bus.snoop_ack      = r_ack;
    assign bus.valid          = r_valid;
    assign bus.exclusive      = r_excl;
    assign bus.dirty          = r_dirty;
    assign bus.data_valid     = r_dvalid;
    assign bus.word_idx       = r_widx;
    assign bus.requested_data = r_dvalid ? bus.data_rdata : 32'd0;
    assign bus.snoop_done     = r_done;
    assign bus.busy           = r_busy;
    assign bus.data_ren       = r_ren;
    assign bus.data_set       = r_dset;
    assign bus.data_word      = r_dword;
    assign bus.cpu_state_out  = r_mesi[bus.cpu_set];

endmodule

// File: tb/tb_l1_snoop_responder.sv
// Scoreboard bench for l1_snoop_responder: directed snoops push expected ack/data/done
// events with their cycle numbers; a negedge monitor pops and compares them.
module tb_l1_snoop_responder;
    localparam int unsigned BS = 2;
    localparam logic [1:0] M = 2'd0, E = 2'd1, S = 2'd2, I = 2'd3;
    localparam logic [1:0] K_ACK = 2'd0, K_DATA = 2'd1, K_DONE = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
        logic        v;
        logic        e;
        logic        d;
        logic        idx;
        logic [31:0] data;
    } ev_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc = 0;
    ev_t         exp_q[$];
    logic [31:0] mem [16][2];

    always #5 CLK = ~CLK;

    l1_snoop_responder_if #(.SET_W(4), .WORD_W(1)) bus ();

    l1_snoop_responder #(.CACHE_SIZE(1024), .BLOCK_SIZE(2), .ASSOC(1)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    // Cycle counter and a one-cycle-latency data array model.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (bus.data_ren) bus.data_rdata <= mem[bus.data_set][bus.data_word];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ev_t mk(input logic [1:0] kind, input int unsigned c, input logic v,
                               input logic e, input logic d, input logic idx,
                               input logic [31:0] data);
        ev_t ev;
        ev.kind = kind; ev.cyc = c; ev.v = v; ev.e = e; ev.d = d; ev.idx = idx; ev.data = data;
        return ev;
    endfunction

    // Monitor: every strobed output must match the head of the scoreboard.
    always @(negedge CLK) begin : monitor
        ev_t act;
        ev_t ex;
        if (bus.snoop_ack || bus.data_valid || bus.snoop_done) begin
            act = mk(bus.snoop_ack ? K_ACK : (bus.data_valid ? K_DATA : K_DONE), cyc,
                     bus.valid, bus.exclusive, bus.dirty, bus.word_idx, bus.requested_data);
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event: got kind=%0d cyc=%0d expected none",
                         act.kind, act.cyc);
            end else begin
                ex = exp_q.pop_front();
                if (act !== ex) begin
                    miscompares++;
                    $display("FAIL event: got kind=%0d cyc=%0d v=%b e=%b d=%b idx=%0d data=%h expected kind=%0d cyc=%0d v=%b e=%b d=%b idx=%0d data=%h",
                             act.kind, act.cyc, act.v, act.e, act.d, act.idx, act.data,
                             ex.kind, ex.cyc, ex.v, ex.e, ex.d, ex.idx, ex.data);
                end
            end
        end else if (nRST) begin
            check("flags_when_idle", {bus.valid, bus.exclusive, bus.dirty, bus.word_idx}, 0);
        end
    end

    task automatic cpu_write(input logic [3:0] set, input logic [1:0] st);
        @(posedge CLK); #1;
        bus.cpu_state_wen = 1'b1; bus.cpu_set = set; bus.cpu_state_in = st;
        @(posedge CLK); #1;
        bus.cpu_state_wen = 1'b0;
    endtask

    task automatic read_state(input string name, input logic [3:0] set, input logic [1:0] exp);
        @(posedge CLK); #1;
        bus.cpu_set = set;
        #1 check(name, bus.cpu_state_out, exp);
    endtask

    // cur is the hand-known line state at lookup time; wen_same writes it in the request cycle.
    task automatic do_snoop(input logic [3:0] set, input logic [1:0] xfer, input logic [1:0] cur,
                            input bit wen_same);
        int unsigned t0;
        bit got;
        @(posedge CLK); #1;
        bus.snoop_req = 1'b1; bus.set_sel = set; bus.state_transfer = xfer;
        if (wen_same) begin
            bus.cpu_state_wen = 1'b1; bus.cpu_set = set; bus.cpu_state_in = cur;
        end
        t0 = cyc;
        exp_q.push_back(mk(K_ACK, t0 + 2, cur != I, (cur == M) || (cur == E), cur == M, 1'b0, 32'd0));
        if (cur == M) begin
            for (int i = 0; i < int'(BS); i++)
                exp_q.push_back(mk(K_DATA, t0 + 4 + i, 1'b0, 1'b0, 1'b0, i[0], mem[set][i]));
            exp_q.push_back(mk(K_DONE, t0 + 4 + BS, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
        end else begin
            exp_q.push_back(mk(K_DONE, t0 + 3, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0));
        end
        @(posedge CLK); #1;
        if (wen_same) bus.cpu_state_wen = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge CLK);
            got = bus.snoop_done;
        end
        check("snoop_done_seen", 64'(got), 1);
        @(posedge CLK); #1;
        bus.snoop_req = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int unsigned t0;
        bus.snoop_req = 1'b0; bus.set_sel = '0; bus.state_transfer = '0;
        bus.cpu_set = '0; bus.cpu_state_wen = 1'b0; bus.cpu_state_in = '0;
        for (int s = 0; s < 16; s++) begin
            mem[s][0] = 32'd0;
            mem[s][1] = 32'd0;
        end
        mem[7][0] = 32'hDEAD0000; mem[7][1] = 32'hDEAD0001;
        mem[2][0] = 32'h22220000; mem[2][1] = 32'h22220001;

        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;
        #1;
        check("reset_outputs", {bus.busy, bus.snoop_ack, bus.snoop_done, bus.data_ren,
                                bus.data_valid, bus.valid, bus.exclusive, bus.dirty}, 0);
        read_state("reset_set5", 4'd5, I);

        // Clean invalid line.
        do_snoop(4'd5, S, I, 1'b0);
        // Clean exclusive line downgraded to shared.
        cpu_write(4'd3, E);
        do_snoop(4'd3, S, E, 1'b0);
        read_state("set3_after", 4'd3, S);
        // Modified line: full flush then invalidate.
        cpu_write(4'd7, M);
        do_snoop(4'd7, I, M, 1'b0);
        read_state("set7_after", 4'd7, I);
        // CPU write in the request cycle is seen by the lookup.
        do_snoop(4'd2, S, M, 1'b1);
        read_state("set2_after", 4'd2, S);
        // CPU write while busy is dropped.
        fork
            do_snoop(4'd0, E, I, 1'b0);
            begin
                @(posedge CLK); @(posedge CLK); #1;
                check("busy_in_lookup", 64'(bus.busy), 1);
                bus.cpu_state_wen = 1'b1; bus.cpu_set = 4'd9; bus.cpu_state_in = E;
                @(posedge CLK); #1;
                bus.cpu_state_wen = 1'b0;
            end
        join
        read_state("set9_dropped", 4'd9, I);
        read_state("set0_after", 4'd0, E);
        // Transfer equal to current state still completes.
        do_snoop(4'd3, S, S, 1'b0);
        read_state("set3_same", 4'd3, S);

        // Reset in the first flush cycle aborts the snoop.
        cpu_write(4'd7, M);
        @(posedge CLK); #1;
        bus.snoop_req = 1'b1; bus.set_sel = 4'd7; bus.state_transfer = I;
        t0 = cyc;
        exp_q.push_back(mk(K_ACK, t0 + 2, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0));
        repeat (3) @(posedge CLK);
        #1;
        check("flush_started", 64'(bus.data_ren), 1);
        nRST = 1'b0; bus.snoop_req = 1'b0;
        @(posedge CLK); #1;
        check("reset_mid_flush", {bus.busy, bus.data_valid, bus.snoop_done, bus.data_ren}, 0);
        nRST = 1'b1;
        repeat (6) @(posedge CLK);
        for (int s = 0; s < 16; s++) read_state("post_reset_invalid", 4'(s), I);

        check("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
